// File: rtl/ttl373_bank_sequencer.sv
// Sequences byte-wide loads into four 74x373-style transparent latches over a shared
// 8-bit bus and gates their output enables once the loaded lanes are stable.
module ttl373_bank_sequencer #(
   parameter int LE_CYCLES     = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [3:0] LANE_MASK,
   input  logic       OUT_EN,
   output logic [3:0] LE,
   output logic [3:0] OE_n,
   output logic [1:0] BYTE_SEL,
   output logic       BUSY,
   output logic       DONE,
   output logic [3:0] LANE_VALID
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_SETTLE,
      ST_DONE
   } state_t;

   localparam logic [3:0] LE_RELOAD     = 4'(LE_CYCLES - 1);
   localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [3:0] mask_rem;
   logic [3:0] rem_next;
   logic [1:0] start_lane;
   logic [1:0] next_lane;

   function automatic logic [1:0] lowest_lane(input logic [3:0] m);
      logic [1:0] l;
      l = 2'd0;
      if (m[0])      l = 2'd0;
      else if (m[1]) l = 2'd1;
      else if (m[2]) l = 2'd2;
      else if (m[3]) l = 2'd3;
      return l;
   endfunction

   function automatic logic [3:0] lane_onehot(input logic [1:0] l);
      return 4'b0001 << l;
   endfunction

   // Remaining lanes once the lane currently addressed by BYTE_SEL is retired.
   always_comb begin
      rem_next   = mask_rem & ~lane_onehot(BYTE_SEL);
      next_lane  = lowest_lane(rem_next);
      start_lane = lowest_lane(LANE_MASK);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         mask_rem   <= 4'd0;
         LE         <= 4'd0;
         OE_n       <= 4'b1111;
         BYTE_SEL   <= 2'd0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         LANE_VALID <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  OE_n <= 4'b1111;
                  BUSY <= 1'b1;
                  if (LANE_MASK != 4'd0) begin
                     state    <= ST_STROBE;
                     mask_rem <= LANE_MASK;
                     BYTE_SEL <= start_lane;
                     LE       <= lane_onehot(start_lane);
                     cnt      <= LE_RELOAD;
                  end else begin
                     state <= ST_DONE;
                     DONE  <= 1'b1;
                     cnt   <= 4'd0;
                  end
               end else begin
                  // Enables follow OUT_EN one cycle late, only for lanes holding valid data.
                  OE_n <= ~({4{OUT_EN & ~BUSY}} & LANE_VALID);
               end
            end

            ST_STROBE: begin
               OE_n <= 4'b1111;
               if (cnt == 4'd0) begin
                  state <= ST_SETTLE;
                  LE    <= 4'd0;
                  cnt   <= SETTLE_RELOAD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            ST_SETTLE: begin
               OE_n <= 4'b1111;
               if (cnt == 4'd0) begin
                  LANE_VALID <= LANE_VALID | lane_onehot(BYTE_SEL);
                  mask_rem   <= rem_next;
                  if (rem_next != 4'd0) begin
                     state    <= ST_STROBE;
                     BYTE_SEL <= next_lane;
                     LE       <= lane_onehot(next_lane);
                     cnt      <= LE_RELOAD;
                  end else begin
                     state <= ST_DONE;
                     DONE  <= 1'b1;
                     cnt   <= 4'd0;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            ST_DONE: begin
               state    <= ST_IDLE;
               OE_n     <= 4'b1111;
               DONE     <= 1'b0;
               BUSY     <= 1'b0;
               mask_rem <= 4'd0;
               cnt      <= 4'd0;
            end

            default: begin
               state <= ST_IDLE;
               LE    <= 4'd0;
               OE_n  <= 4'b1111;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ttl373_bank_sequencer.sv
// Directed bench for ttl373_bank_sequencer with default timing (LE 2 cycles, settle 1 cycle).
module tb_ttl373_bank_sequencer;

   logic       CLK;
   logic       RESET;
   logic       START;
   logic [3:0] LANE_MASK;
   logic       OUT_EN;
   logic [3:0] LE;
   logic [3:0] OE_n;
   logic [1:0] BYTE_SEL;
   logic       BUSY;
   logic       DONE;
   logic [3:0] LANE_VALID;

   int n_tests = 0;
   int n_fail  = 0;

   ttl373_bank_sequencer dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .START      (START),
      .LANE_MASK  (LANE_MASK),
      .OUT_EN     (OUT_EN),
      .LE         (LE),
      .OE_n       (OE_n),
      .BYTE_SEL   (BYTE_SEL),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .LANE_VALID (LANE_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Outputs are read 1 time unit after each rising edge; "cycle k" is the period after edge k.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      START = 1'b0;
      LANE_MASK = 4'd0;
      OUT_EN = 1'b0;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      START = 1'b1;
      LANE_MASK = 4'b1111;
      OUT_EN = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({LE, OE_n, BYTE_SEL, BUSY, DONE, LANE_VALID} !== {4'h0, 4'hf, 2'd0, 1'b0, 1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL reset_state: LE=%b OE_n=%b BYTE_SEL=%0d BUSY=%b DONE=%b LV=%b, want 0000 1111 0 0 0 0000",
                  LE, OE_n, BYTE_SEL, BUSY, DONE, LANE_VALID);
      end
      RESET = 1'b0;
      START = 1'b0;
      OUT_EN = 1'b0;
      tick();
      n_tests++;
      if (BUSY !== 1'b0 || LE !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_priority: BUSY=%b LE=%b, want 0 0000", BUSY, LE);
      end
   endtask

   task automatic test_full_load();
      logic [3:0] le_tab [0:14];
      logic [1:0] bs_tab [0:14];
      le_tab = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
      bs_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
      START = 1'b1;
      LANE_MASK = 4'b1111;
      tick();
      START = 1'b0;
      LANE_MASK = 4'd0;
      for (int k = 1; k <= 14; k++) begin
         n_tests++;
         if (LE !== le_tab[k]) begin
            n_fail++;
            $display("FAIL full_le cycle %0d: LE=%b, want %b", k, LE, le_tab[k]);
         end
         n_tests++;
         if (BYTE_SEL !== bs_tab[k]) begin
            n_fail++;
            $display("FAIL full_byte_sel cycle %0d: got %0d, want %0d", k, BYTE_SEL, bs_tab[k]);
         end
         n_tests++;
         if (BUSY !== (k <= 13) || DONE !== (k == 13)) begin
            n_fail++;
            $display("FAIL full_busy_done cycle %0d: BUSY=%b DONE=%b, want %b %b", k, BUSY, DONE,
                     (k <= 13), (k == 13));
         end
         n_tests++;
         if (OE_n !== 4'hf) begin
            n_fail++;
            $display("FAIL full_oe cycle %0d: OE_n=%b, want 1111", k, OE_n);
         end
         tick();
      end
      n_tests++;
      if (LANE_VALID !== 4'hf) begin
         n_fail++;
         $display("FAIL full_lane_valid: got %b, want 1111", LANE_VALID);
      end
   endtask

   task automatic test_mask_1010();
      logic [3:0] le_tab [0:8];
      le_tab = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
      do_reset();
      START = 1'b1;
      LANE_MASK = 4'b1010;
      tick();
      START = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         n_tests++;
         if (LE !== le_tab[k] || DONE !== (k == 7) || BUSY !== (k <= 7)) begin
            n_fail++;
            $display("FAIL m1010 cycle %0d: LE=%b DONE=%b BUSY=%b, want %b %b %b", k, LE, DONE, BUSY,
                     le_tab[k], (k == 7), (k <= 7));
         end
         if (k == 1 || k == 4) begin
            n_tests++;
            if (BYTE_SEL !== ((k == 1) ? 2'd1 : 2'd3)) begin
               n_fail++;
               $display("FAIL m1010_byte_sel cycle %0d: got %0d, want %0d", k, BYTE_SEL,
                        (k == 1) ? 1 : 3);
            end
         end
         if (k == 4) begin
            n_tests++;
            if (LANE_VALID !== 4'b0010) begin
               n_fail++;
               $display("FAIL m1010_lv_mid: got %b, want 0010", LANE_VALID);
            end
         end
         tick();
      end
      n_tests++;
      if (LANE_VALID !== 4'b1010 || BYTE_SEL !== 2'd3) begin
         n_fail++;
         $display("FAIL m1010_final: LV=%b BYTE_SEL=%0d, want 1010 3", LANE_VALID, BYTE_SEL);
      end
   endtask

   task automatic test_zero_mask();
      START = 1'b1;
      LANE_MASK = 4'b0000;
      tick();
      START = 1'b0;
      n_tests++;
      if (DONE !== 1'b1 || BUSY !== 1'b1 || LE !== 4'h0 || LANE_VALID !== 4'b1010) begin
         n_fail++;
         $display("FAIL zero_mask_done: DONE=%b BUSY=%b LE=%b LV=%b, want 1 1 0000 1010",
                  DONE, BUSY, LE, LANE_VALID);
      end
      tick();
      n_tests++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || LE !== 4'h0) begin
         n_fail++;
         $display("FAIL zero_mask_after: DONE=%b BUSY=%b LE=%b, want 0 0 0000", DONE, BUSY, LE);
      end
      // Only lanes 1 and 3 hold data, so only their enables may drop.
      OUT_EN = 1'b1;
      n_tests++;
      if (OE_n !== 4'hf) begin
         n_fail++;
         $display("FAIL oe_latency: OE_n=%b, want 1111", OE_n);
      end
      tick();
      n_tests++;
      if (OE_n !== 4'b0101) begin
         n_fail++;
         $display("FAIL oe_partial: OE_n=%b, want 0101", OE_n);
      end
      OUT_EN = 1'b0;
      tick();
      n_tests++;
      if (OE_n !== 4'hf) begin
         n_fail++;
         $display("FAIL oe_release: OE_n=%b, want 1111", OE_n);
      end
   endtask

   task automatic test_out_en();
      bit seen;
      do_reset();
      START = 1'b1;
      LANE_MASK = 4'b1111;
      tick();
      START = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (DONE === 1'b1) seen = 1'b1;
         tick();
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL oe_setup_timeout: DONE=%b, want pulse within 40 cycles", DONE);
      end
      OUT_EN = 1'b1;
      tick();
      n_tests++;
      if (OE_n !== 4'h0) begin
         n_fail++;
         $display("FAIL oe_idle_all: OE_n=%b, want 0000", OE_n);
      end
      START = 1'b1;
      LANE_MASK = 4'b0011;
      tick();
      START = 1'b0;
      // Lanes 0 and 1: STROBE/SETTLE cycles 1-6, DONE cycle 7, first IDLE cycle 8.
      for (int k = 1; k <= 9; k++) begin
         n_tests++;
         if (OE_n !== ((k <= 8) ? 4'hf : 4'h0)) begin
            n_fail++;
            $display("FAIL oe_during_load cycle %0d: OE_n=%b, want %b", k, OE_n,
                     (k <= 8) ? 4'hf : 4'h0);
         end
         if (k == 7) begin
            n_tests++;
            if (DONE !== 1'b1) begin
               n_fail++;
               $display("FAIL oe_load_done: DONE=%b, want 1", DONE);
            end
         end
         if (k < 9) tick();
      end
      OUT_EN = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      START = 1'b1;
      LANE_MASK = 4'b1111;
      tick();
      LANE_MASK = 4'b0001;
      OUT_EN = 1'b1;
      for (int k = 1; k < 7; k++) tick();
      n_tests++;
      if (LE !== 4'b0100 || BYTE_SEL !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_strobe_lane2: LE=%b BYTE_SEL=%0d, want 0100 2", LE, BYTE_SEL);
      end
      RESET = 1'b1;
      tick();
      n_tests++;
      if (LE !== 4'h0 || OE_n !== 4'hf || LANE_VALID !== 4'h0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: LE=%b OE_n=%b LV=%b DONE=%b BUSY=%b, want 0000 1111 0000 0 0",
                  LE, OE_n, LANE_VALID, DONE, BUSY);
      end
      RESET = 1'b0;
      START = 1'b0;
      OUT_EN = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_tests++;
         if (DONE !== 1'b0 || LE !== 4'h0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_reset %0d: DONE=%b LE=%b BUSY=%b, want 0 0000 0", k, DONE, LE, BUSY);
         end
      end
   endtask

   initial begin
      RESET = 1'b1;
      START = 1'b0;
      LANE_MASK = 4'd0;
      OUT_EN = 1'b0;
      test_reset();
      test_full_load();
      test_mask_1010();
      test_zero_mask();
      test_out_en();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ttl373_bank_sequencer.md
TTL373_BANK_SEQUENCER -- requirements
Module: ttl373_bank_sequencer

Interface
REQ-001 SHALL provide parameter LE_CYCLES, default 2, cycles LE held high per lane (legal range 1..15).
REQ-002 SHALL provide parameter SETTLE_CYCLES, default 1, cycles LE held low after each strobe before the next lane (legal range 1..15).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  request to load the lanes selected by LANE_MASK; sampled only in IDLE.
REQ-006 SHALL have port LANE_MASK  input  4  lanes to load, bit i = latch i; sampled with START.
REQ-007 SHALL have port OUT_EN  input  1  request to drive loaded lanes onto the 32-bit bus.
REQ-008 SHALL have port LE  output  4  latch-enable strobes to four 8-bit transparent latches, bit i = byte i.
REQ-009 SHALL have port OE_n  output  4  active-low output enables to the same latches.
REQ-010 SHALL have port BYTE_SEL  output  2  byte index the upstream mux must present on the shared 8-bit data bus.
REQ-011 SHALL have port BUSY  output  1  high while a load sequence is in progress.
REQ-012 SHALL have port DONE  output  1  single-cycle pulse on load completion.
REQ-013 SHALL have port LANE_VALID  output  4  bit i set once lane i has been loaded since reset.

Function
REQ-014 SHALL implement states IDLE, STROBE, SETTLE, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with START=1, capture LANE_MASK, select the lowest set bit as current lane, and enter STROBE on the same edge; START=1 outside IDLE SHALL be ignored.
REQ-016 SHALL, in IDLE with START=1 and LANE_MASK=0, enter DONE directly (no LE activity, LANE_VALID unchanged).
REQ-017 SHALL, in STROBE, hold LE[current lane]=1 and all other LE bits 0 for exactly LE_CYCLES cycles, then enter SETTLE.
REQ-018 SHALL, in SETTLE, hold all LE bits 0 for exactly SETTLE_CYCLES cycles; on exit set LANE_VALID[current lane]=1 and enter STROBE for the next higher set mask bit, or DONE if none remain.
REQ-019 SHALL update BYTE_SEL on the edge entering STROBE and hold it constant through the following SETTLE; BYTE_SEL SHALL hold its last value in IDLE.
REQ-020 SHALL never assert more than one LE bit in any cycle.
REQ-021 SHALL assert DONE for exactly one cycle in the DONE state, then return to IDLE.
REQ-022 SHALL assert BUSY in STROBE, SETTLE and DONE; BUSY=0 in IDLE.
REQ-023 SHALL drive OE_n[i] = 0 only when OUT_EN=1, LANE_VALID[i]=1 and BUSY=0, evaluated on the registered path (one-cycle latency from OUT_EN); otherwise OE_n[i]=1.
REQ-024 SHALL force OE_n=4'b1111 from the edge that enters STROBE (START accepted) until the edge returning to IDLE, regardless of OUT_EN.
REQ-025 SHALL use an internal cycle counter wide enough for 15 and reload it on every state entry.
REQ-026 Load of mask 4'b1111 with defaults SHALL take 4x(LE_CYCLES+SETTLE_CYCLES)=12 cycles of STROBE/SETTLE followed by 1 DONE cycle.

Reset
REQ-027 SHALL, on any edge with RESET=1, enter IDLE and set LE=0, OE_n=4'b1111, BYTE_SEL=0, BUSY=0, DONE=0, LANE_VALID=0, counter=0.
REQ-028 SHALL, on RESET mid-sequence, drop the active LE bit at that same edge, discard the captured mask, and not pulse DONE.
REQ-029 SHALL give RESET priority over START and OUT_EN in the same cycle.

Verification
REQ-030 Reset then START=1, LANE_MASK=4'b1111 at edge 0 -> LE=0001 cycles 1-2, 0 cycle 3, 0010 cycles 4-5, 0100 cycles 7-8, 1000 cycles 10-11; DONE=1 cycle 13 only; BUSY=1 cycles 1-13; LANE_VALID=1111 after.
REQ-031 START with LANE_MASK=4'b1010 -> only LE[1] then LE[3] strobe; BYTE_SEL=1 then 3; LANE_VALID=1010; DONE after 6 cycles of STROBE/SETTLE.
REQ-032 START with LANE_MASK=0 -> DONE=1 the next cycle, LE stays 0, BUSY high for one cycle only.
REQ-033 OUT_EN=1 held across a new load of mask 4'b0011 after lanes 0-3 valid -> OE_n=1111 from START accept to DONE, then OE_n=0000 one cycle after IDLE.
REQ-034 RESET=1 during LE[2] strobe -> LE=0, OE_n=1111, LANE_VALID=0, no DONE pulse; START during the sequence ignored.
